sqrt_pipe_stage: RTL and testbench

Parametrised stage for the pipelined integer square-root datapath. Each instance resolves one root bit using incremental square arithmetic. It carries the operand, partial square, partial root and a tag. A valid/ready handshake with a two-entry skid buffer replaces the plain enable-driven stage registers, so stages stall independently and can be flushed. N = IN_W/2 instances chained with BIT_K = N-1 down to 0 form a complete root unit.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_skid_buf.sv | 59 +++++
 rtl/sqrt_pipe_stage.sv | 72 +++++++
 tb/tb_sqrt_pipe_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared widths and payload layout for the pipelined integer square-root datapath.
package sqrt_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int TAG_W_DEF = 4;

  function automatic int root_w(input int in_w);
    return in_w / 2;
  endfunction

  function automatic int sq_w(input int in_w);
    return in_w + 1;
  endfunction

  // Payload layout at default widths. Stages declare the same field order at their own widths.
  typedef struct packed {
    logic [IN_W_DEF-1:0]          operand;
    logic [sq_w(IN_W_DEF)-1:0]    square;
    logic [root_w(IN_W_DEF)-1:0]  root;
    logic [TAG_W_DEF-1:0]         tag;
  } payload_def_t;

endpackage

// File: rtl/sqrt_skid_buf.sv
// Two-entry valid/ready skid buffer, 1-cycle latency, full throughput.
// in_ready_o comes straight from the skid flag, so there is no combinational path from out_ready_i.
module sqrt_skid_buf
  import sqrt_pkg::*;
#(
  parameter type payload_t = payload_def_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  payload_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output payload_t out_data_o
);

  logic     main_vld, skid_vld;
  payload_t main_dat, skid_dat;
  logic     push, pop;

  assign in_ready_o  = !skid_vld;
  assign out_valid_o = main_vld;
  assign out_data_o  = main_dat;
  assign push        = in_valid_i && !skid_vld;
  assign pop         = main_vld && out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush_i) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld) begin
      // skid is only ever filled behind a full main, so it is empty here
      if (push) begin
        main_vld <= 1'b1;
        main_dat <= in_data_i;
      end
    end else if (pop) begin
      if (skid_vld) begin
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else if (push) begin
        main_dat <= in_data_i;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (push) begin
      skid_vld <= 1'b1;
      skid_dat <= in_data_i;
    end
  end

endmodule

// File: rtl/sqrt_pipe_stage.sv
// One root-bit stage of the pipelined square root: trial square compare ahead of a skid buffer.
// Latency 1 cycle, 1 result/cycle; absorbs one extra entry on stall, then drops in_ready_o.
module sqrt_pipe_stage
  import sqrt_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int BIT_K  = root_w(IN_W) - 1,
  parameter  int TAG_W  = TAG_W_DEF,
  localparam int ROOT_W = root_w(IN_W),
  localparam int SQ_W   = sq_w(IN_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   in_input_i,
  input  logic [SQ_W-1:0]   in_square_i,
  input  logic [ROOT_W-1:0] in_root_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IN_W-1:0]   out_input_o,
  output logic [SQ_W-1:0]   out_square_o,
  output logic [ROOT_W-1:0] out_root_o,
  output logic [TAG_W-1:0]  out_tag_o
);

  // One extra bit so the trial square never wraps before the compare.
  localparam int EW = SQ_W + 1;

  typedef struct packed {
    logic [IN_W-1:0]   operand;
    logic [SQ_W-1:0]   square;
    logic [ROOT_W-1:0] root;
    logic [TAG_W-1:0]  tag;
  } payload_t;

  logic [EW-1:0] trial_sq;
  logic          accept;
  payload_t      in_pl, out_pl;

  // (r + 2^k)^2 = r^2 + r*2^(k+1) + 2^(2k)
  always_comb begin
    trial_sq = EW'(in_square_i) + (EW'(in_root_i) << (BIT_K + 1)) + (EW'(1) << (2 * BIT_K));
    accept   = trial_sq <= EW'(in_input_i);
    in_pl.operand = in_input_i;
    in_pl.tag     = in_tag_i;
    in_pl.root    = accept ? (in_root_i | (ROOT_W'(1) << BIT_K)) : in_root_i;
    in_pl.square  = accept ? trial_sq[SQ_W-1:0] : in_square_i;
  end

  sqrt_skid_buf #(
    .payload_t (payload_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pl),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_pl)
  );

  assign out_input_o  = out_pl.operand;
  assign out_square_o = out_pl.square;
  assign out_root_o   = out_pl.root;
  assign out_tag_o    = out_pl.tag;

endmodule

// File: tb/tb_sqrt_pipe_stage.sv
// Bench for sqrt_pipe_stage: single stages at BIT_K=7 and BIT_K=0, plus an 8-stage root chain.
module tb_sqrt_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: accept the bit when (root + 2^k)^2 still fits under the radicand.
  function automatic void ref_stage(input int x, input int r, input int sq, input int k,
                                    output int ro, output int so);
    int t;
    t = r + (1 << k);
    if (t * t <= x) begin ro = t; so = t * t; end
    else begin ro = r; so = sq; end
  endfunction

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Stage A: BIT_K = 7
  logic        a_flush, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
  logic [15:0] a_in_x, a_out_x;
  logic [16:0] a_in_sq, a_out_sq;
  logic [7:0]  a_in_root, a_out_root;
  logic [3:0]  a_in_tag, a_out_tag;

  sqrt_pipe_stage #(.IN_W(16), .BIT_K(7), .TAG_W(4)) u_s7 (
    .clk(clk), .rst(rst), .flush_i(a_flush),
    .in_valid_i(a_in_vld), .in_ready_o(a_in_rdy),
    .in_input_i(a_in_x), .in_square_i(a_in_sq), .in_root_i(a_in_root), .in_tag_i(a_in_tag),
    .out_valid_o(a_out_vld), .out_ready_i(a_out_rdy),
    .out_input_o(a_out_x), .out_square_o(a_out_sq), .out_root_o(a_out_root), .out_tag_o(a_out_tag)
  );

  // Stage B: BIT_K = 0
  logic        b_flush, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
  logic [15:0] b_in_x, b_out_x;
  logic [16:0] b_in_sq, b_out_sq;
  logic [7:0]  b_in_root, b_out_root;
  logic [3:0]  b_in_tag, b_out_tag;

  sqrt_pipe_stage #(.IN_W(16), .BIT_K(0), .TAG_W(4)) u_s0 (
    .clk(clk), .rst(rst), .flush_i(b_flush),
    .in_valid_i(b_in_vld), .in_ready_o(b_in_rdy),
    .in_input_i(b_in_x), .in_square_i(b_in_sq), .in_root_i(b_in_root), .in_tag_i(b_in_tag),
    .out_valid_o(b_out_vld), .out_ready_i(b_out_rdy),
    .out_input_o(b_out_x), .out_square_o(b_out_sq), .out_root_o(b_out_root), .out_tag_o(b_out_tag)
  );

  // Full 8-stage chain
  logic        ch_flush, ch_in_vld, ch_out_rdy;
  logic [15:0] ch_in_x;
  logic [3:0]  ch_in_tag;
  logic        c_vld  [9];
  logic        c_rdy  [9];
  logic [15:0] c_x    [9];
  logic [16:0] c_sq   [9];
  logic [7:0]  c_root [9];
  logic [3:0]  c_tag  [9];

  assign c_vld[0]  = ch_in_vld;
  assign c_x[0]    = ch_in_x;
  assign c_sq[0]   = '0;
  assign c_root[0] = '0;
  assign c_tag[0]  = ch_in_tag;
  assign c_rdy[8]  = ch_out_rdy;

  for (genvar g = 0; g < 8; g++) begin : g_chain
    sqrt_pipe_stage #(.IN_W(16), .BIT_K(7 - g), .TAG_W(4)) u_stage (
      .clk(clk), .rst(rst), .flush_i(ch_flush),
      .in_valid_i(c_vld[g]), .in_ready_o(c_rdy[g]),
      .in_input_i(c_x[g]), .in_square_i(c_sq[g]), .in_root_i(c_root[g]), .in_tag_i(c_tag[g]),
      .out_valid_o(c_vld[g+1]), .out_ready_i(c_rdy[g+1]),
      .out_input_o(c_x[g+1]), .out_square_o(c_sq[g+1]), .out_root_o(c_root[g+1]), .out_tag_o(c_tag[g+1])
    );
  end

  typedef struct {
    bit k0;
    int x;
    int r;
    int sq;
    int er;
    int esq;
  } vec_t;

  typedef struct {
    int x;
    int root;
    int sq;
    int tag;
  } exp_t;

  vec_t vt [8];

  // Streams n items through stage A; sched=1 holds out_ready_i low for cycles 2..4.
  task automatic run_stream(input int n, input bit sched);
    exp_t q[$];
    exp_t e;
    int sent, got, cyc, stall;
    sent = 0; got = 0; cyc = 0; stall = 0;
    a_in_root = '0;
    a_in_sq   = '0;
    while (got < n && cyc < 400) begin
      a_out_rdy = sched ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(0, 2) != 0);
      if (sent < n && (sched || $urandom_range(0, 3) != 0)) begin
        a_in_vld = 1'b1;
        a_in_x   = 16'($urandom_range(0, 65535));
        a_in_tag = sent[3:0];
      end else begin
        a_in_vld = 1'b0;
      end
      check("stream_in_ready", a_in_rdy, q.size() < 2);
      check("stream_out_valid", a_out_vld, q.size() > 0);
      if (!a_in_rdy) stall++;
      if (a_out_vld && q.size() > 0) begin
        check("stream_tag", a_out_tag, q[0].tag);
        check("stream_root", a_out_root, q[0].root);
        check("stream_square", a_out_sq, q[0].sq);
        check("stream_input", a_out_x, q[0].x);
        if (a_out_rdy) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (a_in_vld && a_in_rdy) begin
        e.x = int'(a_in_x);
        e.tag = sent % 16;
        ref_stage(e.x, 0, 0, 7, e.root, e.sq);
        q.push_back(e);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_vld  = 1'b0;
    a_out_rdy = 1'b1;
    check("stream_delivered", got, n);
    if (sched) check("stream_stall_cycles", stall, 3);
  endtask

  task automatic run_chain(input int n_rand);
    int xs[$];
    exp_t q[$];
    exp_t e;
    int sent, got, cyc, n;
    xs = '{0, 1, 65535, 65534, 65025, 65024, 16384, 16383, 255, 256};
    for (int i = 0; i < n_rand; i++) xs.push_back(int'($urandom_range(0, 65535)));
    n = xs.size();
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 10000) begin
      ch_out_rdy = ($urandom_range(0, 3) != 0);
      if (sent < n && $urandom_range(0, 3) != 0) begin
        ch_in_vld = 1'b1;
        ch_in_x   = 16'(xs[sent]);
        ch_in_tag = sent[3:0];
      end else begin
        ch_in_vld = 1'b0;
      end
      if (c_vld[8] && ch_out_rdy) begin
        if (q.size() == 0) begin
          check("chain_spurious_output", 1, 0);
        end else begin
          check("chain_root", c_root[8], q[0].root);
          check("chain_square", c_sq[8], q[0].sq);
          check("chain_input", c_x[8], q[0].x);
          check("chain_tag", c_tag[8], q[0].tag);
          void'(q.pop_front());
        end
        got++;
      end
      if (ch_in_vld && c_rdy[0]) begin
        e.x = xs[sent];
        e.root = isqrt(e.x);
        e.sq = e.root * e.root;
        e.tag = sent % 16;
        q.push_back(e);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    ch_in_vld = 1'b0;
    check("chain_delivered", got, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_flush = 0; a_in_vld = 0; a_out_rdy = 0; a_in_x = '0; a_in_sq = '0; a_in_root = '0; a_in_tag = '0;
    b_flush = 0; b_in_vld = 0; b_out_rdy = 0; b_in_x = '0; b_in_sq = '0; b_in_root = '0; b_in_tag = '0;
    ch_flush = 0; ch_in_vld = 0; ch_out_rdy = 0; ch_in_x = '0; ch_in_tag = '0;

    repeat (2) @(negedge clk);
    check("reset_out_valid", a_out_vld, 0);
    check("reset_in_ready", a_in_rdy, 1);
    check("reset_root", a_out_root, 0);
    check("reset_square", a_out_sq, 0);
    check("reset_input", a_out_x, 0);
    check("reset_tag", a_out_tag, 0);
    check("reset_chain_ready", c_rdy[0], 1);
    rst = 1'b0;

    // Directed single-stage vectors
    vt[0] = '{0, 65535, 0, 0, 128, 16384};
    vt[1] = '{0, 100, 0, 0, 0, 0};
    vt[2] = '{0, 16384, 0, 0, 128, 16384};
    vt[3] = '{0, 16383, 0, 0, 0, 0};
    vt[4] = '{1, 10, 2, 4, 3, 9};
    vt[5] = '{1, 8, 2, 4, 2, 4};
    vt[6] = '{1, 9, 2, 4, 3, 9};
    vt[7] = '{1, 65535, 254, 64516, 255, 65025};
    a_out_rdy = 1'b1;
    b_out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].k0) begin
        b_in_vld = 1'b1; b_in_x = 16'(vt[i].x); b_in_root = 8'(vt[i].r);
        b_in_sq = 17'(vt[i].sq); b_in_tag = 4'(i);
      end else begin
        a_in_vld = 1'b1; a_in_x = 16'(vt[i].x); a_in_root = 8'(vt[i].r);
        a_in_sq = 17'(vt[i].sq); a_in_tag = 4'(i);
      end
      @(negedge clk);
      if (vt[i].k0) begin
        check($sformatf("vec%0d_valid", i), b_out_vld, 1);
        check($sformatf("vec%0d_root", i), b_out_root, vt[i].er);
        check($sformatf("vec%0d_square", i), b_out_sq, vt[i].esq);
        check($sformatf("vec%0d_tag", i), b_out_tag, i);
      end else begin
        check($sformatf("vec%0d_valid", i), a_out_vld, 1);
        check($sformatf("vec%0d_root", i), a_out_root, vt[i].er);
        check($sformatf("vec%0d_square", i), a_out_sq, vt[i].esq);
        check($sformatf("vec%0d_tag", i), a_out_tag, i);
      end
      a_in_vld = 1'b0;
      b_in_vld = 1'b0;
    end
    @(negedge clk);

    run_stream(6, 1'b1);
    run_stream(40, 1'b0);
    repeat (3) @(negedge clk);

    // Flush with main and skid full and a third item presented
    a_out_rdy = 1'b0; a_in_root = '0; a_in_sq = '0;
    a_in_vld = 1'b1; a_in_x = 16'd65535; a_in_tag = 4'd1;
    @(negedge clk);
    a_in_tag = 4'd2;
    @(negedge clk);
    check("flush_pre_skid_full", a_in_rdy, 0);
    a_in_tag = 4'd3; a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0; a_in_vld = 1'b0;
    check("flush_out_valid", a_out_vld, 0);
    check("flush_in_ready", a_in_rdy, 1);
    a_out_rdy = 1'b1;
    a_in_vld = 1'b1; a_in_x = 16'd100; a_in_tag = 4'd4;
    @(negedge clk);
    a_in_vld = 1'b0;
    check("post_flush_valid", a_out_vld, 1);
    check("post_flush_tag", a_out_tag, 4);
    check("post_flush_root", a_out_root, 0);
    @(negedge clk);
    check("post_flush_drained", a_out_vld, 0);

    // Asynchronous reset in mid-stall
    a_out_rdy = 1'b0;
    a_in_vld = 1'b1; a_in_x = 16'd65535; a_in_tag = 4'd5;
    @(negedge clk);
    a_in_tag = 4'd6;
    @(negedge clk);
    a_in_vld = 1'b0;
    check("stall_pre_valid", a_out_vld, 1);
    check("stall_pre_ready", a_in_rdy, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", a_out_vld, 0);
    check("async_rst_in_ready", a_in_rdy, 1);
    check("async_rst_root", a_out_root, 0);
    check("async_rst_square", a_out_sq, 0);
    check("async_rst_input", a_out_x, 0);
    check("async_rst_tag", a_out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    a_out_rdy = 1'b1;
    a_in_vld = 1'b1; a_in_x = 16'd65535; a_in_tag = 4'd7;
    @(negedge clk);
    a_in_vld = 1'b0;
    check("after_rst_valid", a_out_vld, 1);
    check("after_rst_root", a_out_root, 128);
    check("after_rst_square", a_out_sq, 16384);
    check("after_rst_tag", a_out_tag, 7);
    @(negedge clk);
    check("after_rst_drained", a_out_vld, 0);

    run_chain(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
